key_debounce_array: RTL and testbench

- Parametrised successor to the board pushbutton conditioner: N independent key channels.
- Per channel: 2-FF synchroniser, tick-based stability debounce, clean level, one-clk press/release pulses, optional typematic auto-repeat.
- Sits between the board KEY pins and game control logic (direction input, start/pause).
- Shared prescaler generates the sample tick; all outputs are synchronous to clk.

---
 rtl/key_debounce_array.sv | 172 +++++++++++++++++
 tb/tb_key_debounce_array.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// N-channel key conditioner: 2-FF sync, tick-sampled debounce,
// press/release pulses and optional typematic auto-repeat.
module key_debounce_array #(
    parameter int N_KEYS        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int TICK_DIV      = 250000,
    parameter int STABLE_TICKS  = 4,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 100,
    parameter int REPEAT_PERIOD = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [N_KEYS-1:0] INV = {N_KEYS{(ACTIVE_LOW != 0)}};

    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);

    logic [CW-1:0]     r_div;
    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_raw;
    logic              w_tick;

    assign w_tick = (r_div == TICK_LAST);
    assign w_raw  = r_sync2 ^ INV;
    assign tick   = w_tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CW'(1);
        end
    end

    // Synchroniser idles at the released pin level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= INV;
            r_sync2 <= INV;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic [SW-1:0] r_stab;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          w_accept;
        logic          w_acc_press;
        logic          w_acc_rel;

        assign w_accept = w_tick
                        & (w_raw[g] != r_level)
                        & (r_stab == STAB_LAST);
        assign w_acc_press = w_accept & w_raw[g];
        assign w_acc_rel   = w_accept & ~w_raw[g];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_stab    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (w_tick) begin
                    if (w_raw[g] == r_level) begin
                        r_stab <= '0;
                    end else if (w_accept) begin
                        r_level   <= w_raw[g];
                        r_stab    <= '0;
                        r_press   <= w_raw[g];
                        r_release <= ~w_raw[g];
                    end else begin
                        r_stab <= r_stab + SW'(1);
                    end
                end
            end
        end

        assign key_level[g]   = r_level;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;

        if (REPEAT_EN != 0) begin : g_rep
            localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                  REPEAT_DELAY : REPEAT_PERIOD;
            localparam int HW = $clog2(HMAX + 1);
            localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
            localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

            typedef enum logic [1:0] {
                S_IDLE,
                S_DELAY,
                S_REPEAT
            } state_t;

            state_t        r_state;
            logic [HW-1:0] r_hold;
            logic          r_repeat;

            // Press/release acceptance overrides tick counting, so the
            // accept tick never counts toward the delay.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_state  <= S_IDLE;
                    r_hold   <= '0;
                    r_repeat <= 1'b0;
                end else begin
                    r_repeat <= 1'b0;
                    if (w_acc_press) begin
                        r_state <= S_DELAY;
                        r_hold  <= '0;
                    end else if (w_acc_rel) begin
                        r_state <= S_IDLE;
                        r_hold  <= '0;
                    end else if (w_tick) begin
                        unique case (r_state)
                            S_IDLE: begin
                                r_hold <= '0;
                            end
                            S_DELAY: begin
                                if (r_hold == DLY_LAST) begin
                                    r_repeat <= 1'b1;
                                    r_hold   <= '0;
                                    r_state  <= S_REPEAT;
                                end else begin
                                    r_hold <= r_hold + HW'(1);
                                end
                            end
                            S_REPEAT: begin
                                if (r_hold == PER_LAST) begin
                                    r_repeat <= 1'b1;
                                    r_hold   <= '0;
                                end else begin
                                    r_hold <= r_hold + HW'(1);
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_hold  <= '0;
                            end
                        endcase
                    end
                end
            end

            assign key_repeat[g] = r_repeat;
        end else begin : g_norep
            assign key_repeat[g] = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: directed scenarios plus random key
// activity, every cycle compared against a tick-history reference model.
module tb_key_debounce_array;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RP = 2;

    logic         clk    = 1'b0;
    logic         resetn = 1'b1;
    logic [N-1:0] KEY    = '1;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_repeat;
    logic         tick;

    key_debounce_array #(
        .N_KEYS(N), .ACTIVE_LOW(1), .TICK_DIV(TD),
        .STABLE_TICKS(ST), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .resetn(resetn), .KEY(KEY),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_repeat(key_repeat),
        .tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    int           e;
    logic [N-1:0] k1, k2;
    logic [N-1:0] mlev, epr, erl, erp;
    logic         etk;
    logic [N-1:0] hist[$];
    int           acc_t[N];
    int           tp[N];

    // event bookkeeping
    int cyc_n;
    int npress[N], nrel[N], nrep[N], nrep_late[N];
    int pcyc[N], rcyc[N];
    int repq[$];
    int start, first, nt;

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e = 0;
        k1 = '1;
        k2 = '1;
        mlev = '0;
        epr = '0;
        erl = '0;
        erp = '0;
        etk = 1'b0;
        hist.delete();
        hist.push_back('0);
        for (int c = 0; c < N; c++) begin
            acc_t[c] = 0;
            tp[c] = -1;
        end
    endtask

    // A level is accepted once the last ST tick samples (all taken after
    // the previous acceptance) disagree with it. Repeats fall at tick
    // distances RD, RD+RP, RD+2RP... from the press tick.
    task automatic model_edge();
        logic [N-1:0] raw;
        int t;
        bit acc;
        int d;
        e++;
        raw = ~k2;
        k2 = k1;
        k1 = KEY;
        epr = '0;
        erl = '0;
        erp = '0;
        if (e % TD == 0) begin
            t = e / TD;
            hist.push_back(raw);
            for (int c = 0; c < N; c++) begin
                acc = (t - acc_t[c] >= ST);
                if (acc)
                    for (int j = 0; j < ST; j++)
                        if (hist[t-j][c] == mlev[c]) acc = 0;
                if (acc) begin
                    acc_t[c] = t;
                    mlev[c] = raw[c];
                    if (raw[c]) begin
                        epr[c] = 1'b1;
                        tp[c] = t;
                    end else begin
                        erl[c] = 1'b1;
                        tp[c] = -1;
                    end
                end else if (mlev[c] && tp[c] >= 0) begin
                    d = t - tp[c];
                    if (d >= RD && (d - RD) % RP == 0) erp[c] = 1'b1;
                end
            end
        end
        etk = (e % TD == TD - 1);
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < N; c++) begin
            npress[c] = 0;
            nrel[c] = 0;
            nrep[c] = 0;
            nrep_late[c] = 0;
            pcyc[c] = -1;
            rcyc[c] = -1;
        end
        repq.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_edge();
        cyc_n++;
        chk("level", key_level, mlev);
        chk("press", key_press, epr);
        chk("release", key_release, erl);
        chk("repeat", key_repeat, erp);
        chk("tick", N'(tick), N'(etk));
        for (int c = 0; c < N; c++) begin
            if (key_press[c]) begin
                npress[c]++;
                pcyc[c] = cyc_n;
            end
            if (key_release[c]) begin
                nrel[c]++;
                rcyc[c] = cyc_n;
            end
            if (key_repeat[c]) begin
                nrep[c]++;
                if (rcyc[c] >= 0) nrep_late[c]++;
                if (c == 0) repq.push_back(cyc_n);
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_level", key_level, '0);
        chk("rst_press", key_press, '0);
        chk("rst_release", key_release, '0);
        chk("rst_repeat", key_repeat, '0);
        chk("rst_tick", N'(tick), '0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cyc_n = 0;
    endtask

    task automatic burst1();
        repeat (4) begin
            KEY[1] = 1'b0;
            repeat (6) cyc();
            KEY[1] = 1'b1;
            repeat (2) cyc();
        end
    endtask

    initial begin
        model_reset();
        clr_cnt();
        cyc_n = 0;
        #2;
        do_reset();

        // prescaler
        first = -1;
        nt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (tick) begin
                nt++;
                if (first < 0) first = cyc_n;
            end
        end
        chk_i("tick_first", first, TD - 1);
        chk_i("tick_count", nt, 3);

        // clean press with auto-repeat
        clr_cnt();
        KEY[0] = 1'b0;
        start = cyc_n;
        repeat (60) cyc();
        chk_i("press0_cnt", npress[0], 1);
        chk_i("press0_lat", int'(pcyc[0] - start <= 15), 1);
        chk("press0_level", N'(key_level[0]), N'(1));
        chk_i("others_silent", npress[1] + npress[2] + npress[3], 0);
        chk_i("rep_seen", int'(repq.size() >= 2), 1);
        if (repq.size() >= 2) begin
            chk_i("rep_first", repq[0] - pcyc[0], 20);
            chk_i("rep_period", repq[1] - repq[0], 8);
        end

        // release
        clr_cnt();
        KEY[0] = 1'b1;
        start = cyc_n;
        repeat (24) cyc();
        chk_i("rel0_cnt", nrel[0], 1);
        chk_i("rel0_lat", int'(rcyc[0] - start <= 15), 1);
        chk("rel0_level", N'(key_level[0]), '0);
        chk_i("rel0_norep", nrep_late[0], 0);

        // bounce rejection, aligned so every 2-clk high gets sampled
        clr_cnt();
        while (e % TD != 2) cyc();
        burst1();
        repeat (20) cyc();
        chk_i("bounce_nopress", npress[1], 0);
        chk("bounce_level", N'(key_level[1]), '0);

        clr_cnt();
        burst1();
        KEY[1] = 1'b0;
        repeat (40) cyc();
        chk_i("bounce_hold_press", npress[1], 1);
        KEY[1] = 1'b1;
        repeat (24) cyc();

        // simultaneous press
        clr_cnt();
        KEY[3:2] = 2'b00;
        repeat (24) cyc();
        chk_i("sim_press2", npress[2], 1);
        chk_i("sim_press3", npress[3], 1);
        chk_i("sim_same_cyc", pcyc[3], pcyc[2]);
        KEY[3:2] = 2'b11;
        repeat (24) cyc();

        // reset while repeating
        clr_cnt();
        KEY[0] = 1'b0;
        repeat (50) cyc();
        chk_i("mid_in_repeat", int'(nrep[0] > 0), 1);
        do_reset();
        clr_cnt();
        repeat (40) cyc();
        chk_i("mid_press_cyc", pcyc[0], ST * TD);
        chk_i("mid_press_cnt", npress[0], 1);
        chk_i("mid_rep_seen", int'(repq.size() >= 1), 1);
        if (repq.size() >= 1)
            chk_i("mid_rep_first", repq[0], (ST + RD) * TD);
        KEY[0] = 1'b1;
        repeat (24) cyc();

        // random activity on all channels
        repeat (150) begin
            KEY = N'($urandom);
            repeat ($urandom_range(1, 30)) cyc();
        end
        KEY = '1;
        repeat (30) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
